// File: rtl/alu_arbiter_if.sv
// ============================================================================
// alu_arbiter_if : command/response channel between one requester and the
//                  shared-ALU arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface alu_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_funct3;
  logic [6:0]       req_funct7;
  logic [XLEN-1:0]  req_op1;
  logic [XLEN-1:0]  req_op2;
  logic [TAG_W-1:0] req_tag;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [XLEN-1:0]  rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_illegal;

  modport master (
    output req_valid, req_funct3, req_funct7, req_op1, req_op2, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_tag, rsp_illegal
  );

  modport slave (
    input  req_valid, req_funct3, req_funct7, req_op1, req_op2, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_tag, rsp_illegal
  );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// alu_arbiter : round-robin sharing of one combinational ALU between two
//               requesters, each with a single-entry registered response.
// Optional macro: ALU_ARB_ILLEGAL_CHK_EN (flag and zero illegal ops).
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_arbiter #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_arbiter_if.slave    req0_if,
  alu_arbiter_if.slave    req1_if,
  output logic [2:0]      alu_funct3_o,
  output logic [6:0]      alu_funct7_o,
  output logic [XLEN-1:0] alu_operand_1_o,
  output logic [XLEN-1:0] alu_operand_2_o,
  input  logic [XLEN-1:0] alu_result_i
);

  logic [1:0]       req_valid;
  logic [1:0]       rsp_ready;
  logic [1:0]       elig;
  logic [1:0]       grant;
  logic             rr_ptr_q;
  logic             rr_ptr_d;
  logic [TAG_W-1:0] cap_tag;
  logic [XLEN-1:0]  cap_result;
  logic             cap_illegal;

  logic [1:0]       rsp_valid_q;
  logic [1:0]       rsp_illegal_q;
  logic [XLEN-1:0]  rsp_result_q [2];
  logic [TAG_W-1:0] rsp_tag_q    [2];

  assign req_valid = {req1_if.req_valid, req0_if.req_valid};
  assign rsp_ready = {req1_if.rsp_ready, req0_if.rsp_ready};

  // A slot is free when empty or being drained this very cycle.
  assign elig = req_valid & (~rsp_valid_q | rsp_ready);

  always_comb begin
    grant = 2'b00;
    if (rst_n) begin
      if (&elig) begin
        grant = rr_ptr_q ? 2'b10 : 2'b01;
      end else begin
        grant = elig;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant[0]) begin
      rr_ptr_d = 1'b1;
    end else if (grant[1]) begin
      rr_ptr_d = 1'b0;
    end
  end

  // Idle ALU sees ADD 0+0 so nothing undefined leaks downstream.
  always_comb begin
    alu_funct3_o    = 3'b000;
    alu_funct7_o    = 7'b0000000;
    alu_operand_1_o = '0;
    alu_operand_2_o = '0;
    cap_tag         = '0;
    if (grant[0]) begin
      alu_funct3_o    = req0_if.req_funct3;
      alu_funct7_o    = req0_if.req_funct7;
      alu_operand_1_o = req0_if.req_op1;
      alu_operand_2_o = req0_if.req_op2;
      cap_tag         = req0_if.req_tag;
    end else if (grant[1]) begin
      alu_funct3_o    = req1_if.req_funct3;
      alu_funct7_o    = req1_if.req_funct7;
      alu_operand_1_o = req1_if.req_op1;
      alu_operand_2_o = req1_if.req_op2;
      cap_tag         = req1_if.req_tag;
    end
  end

`ifdef ALU_ARB_ILLEGAL_CHK_EN
  function automatic logic is_illegal(input logic [6:0] f7, input logic [2:0] f3);
    logic legal;
    legal = (f7 == 7'b0000000) ||
            ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
    return !legal;
  endfunction

  assign cap_illegal = (|grant) && is_illegal(alu_funct7_o, alu_funct3_o);
  assign cap_result  = cap_illegal ? '0 : alu_result_i;
`else
  assign cap_illegal = 1'b0;
  assign cap_result  = alu_result_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= 1'b0;
      rsp_valid_q   <= 2'b00;
      rsp_illegal_q <= 2'b00;
      for (int n = 0; n < 2; n++) begin
        rsp_result_q[n] <= '0;
        rsp_tag_q[n]    <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int n = 0; n < 2; n++) begin
        if (grant[n]) begin
          rsp_valid_q[n]   <= 1'b1;
          rsp_result_q[n]  <= cap_result;
          rsp_tag_q[n]     <= cap_tag;
          rsp_illegal_q[n] <= cap_illegal;
        end else if (rsp_ready[n]) begin
          rsp_valid_q[n]   <= 1'b0;
        end
      end
    end
  end

  assign req0_if.req_ready   = grant[0];
  assign req1_if.req_ready   = grant[1];
  assign req0_if.rsp_valid   = rsp_valid_q[0];
  assign req1_if.rsp_valid   = rsp_valid_q[1];
  assign req0_if.rsp_result  = rsp_result_q[0];
  assign req1_if.rsp_result  = rsp_result_q[1];
  assign req0_if.rsp_tag     = rsp_tag_q[0];
  assign req1_if.rsp_tag     = rsp_tag_q[1];
  assign req0_if.rsp_illegal = rsp_illegal_q[0];
  assign req1_if.rsp_illegal = rsp_illegal_q[1];

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// tb_alu_arbiter : directed self-checking bench for alu_arbiter with a small
//                  RV32 ALU model standing in for the shared ALU.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  alu_funct3;
  logic [6:0]  alu_funct7;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [31:0] alu_result;

  int passes = 0;
  int total  = 0;

  alu_arbiter_if #(.XLEN(32), .TAG_W(4)) r0_if ();
  alu_arbiter_if #(.XLEN(32), .TAG_W(4)) r1_if ();

  alu_arbiter #(.XLEN(32), .TAG_W(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req0_if         (r0_if),
    .req1_if         (r1_if),
    .alu_funct3_o    (alu_funct3),
    .alu_funct7_o    (alu_funct7),
    .alu_operand_1_o (alu_op1),
    .alu_operand_2_o (alu_op2),
    .alu_result_i    (alu_result)
  );

  always #5 clk = ~clk;

  // Reference ALU; unknown encodings return X like an undecoded real ALU.
  always_comb begin
    alu_result = 'x;
    if (alu_funct7 == 7'h00) begin
      case (alu_funct3)
        3'b000: alu_result = alu_op1 + alu_op2;
        3'b001: alu_result = alu_op1 << alu_op2[4:0];
        3'b010: alu_result = {31'd0, $signed(alu_op1) < $signed(alu_op2)};
        3'b011: alu_result = {31'd0, alu_op1 < alu_op2};
        3'b100: alu_result = alu_op1 ^ alu_op2;
        3'b101: alu_result = alu_op1 >> alu_op2[4:0];
        3'b110: alu_result = alu_op1 | alu_op2;
        default: alu_result = alu_op1 & alu_op2;
      endcase
    end else if (alu_funct7 == 7'h20 && alu_funct3 == 3'b000) begin
      alu_result = alu_op1 - alu_op2;
    end else if (alu_funct7 == 7'h20 && alu_funct3 == 3'b101) begin
      alu_result = $unsigned($signed(alu_op1) >>> alu_op2[4:0]);
    end
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed=%h expected=%h", name, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [6:0] f7, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    r0_if.req_valid = v; r0_if.req_funct7 = f7; r0_if.req_funct3 = f3;
    r0_if.req_op1 = a; r0_if.req_op2 = b; r0_if.req_tag = t;
  endtask

  task automatic drive1(input logic v, input logic [6:0] f7, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    r1_if.req_valid = v; r1_if.req_funct7 = f7; r1_if.req_funct3 = f3;
    r1_if.req_op1 = a; r1_if.req_op2 = b; r1_if.req_tag = t;
  endtask

  initial begin
    drive0(1'b1, 7'h00, 3'b000, 32'd1, 32'd1, 4'd1);
    drive1(1'b1, 7'h00, 3'b000, 32'd1, 32'd1, 4'd1);
    r0_if.rsp_ready = 1'b1;
    r1_if.rsp_ready = 1'b1;

    // Reset state, with requests pending.
    #2;
    check("rst_rsp0_valid", r0_if.rsp_valid, 0);
    check("rst_rsp1_valid", r1_if.rsp_valid, 0);
    check("rst_req0_ready", r0_if.req_ready, 0);
    check("rst_req1_ready", r1_if.req_ready, 0);
    check("rst_rsp0_result", r0_if.rsp_result, 0);
    check("rst_rsp1_tag", r1_if.rsp_tag, 0);
    check("rst_rsp0_illegal", r0_if.rsp_illegal, 0);
    drive0(1'b0, 7'h00, 3'b000, 32'd0, 32'd0, 4'd0);
    drive1(1'b0, 7'h00, 3'b000, 32'd0, 32'd0, 4'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("idle_alu_op1", alu_op1, 0);
    check("idle_alu_f7", alu_funct7, 0);

    // Single-op latency: ADD 5+7.
    drive0(1'b1, 7'h00, 3'b000, 32'd5, 32'd7, 4'd3);
    #1;
    check("lat_req0_ready", r0_if.req_ready, 1);
    check("lat_alu_op1", alu_op1, 5);
    step();
    drive0(1'b0, 7'h00, 3'b000, 32'd0, 32'd0, 4'd0);
    check("lat_rsp0_valid", r0_if.rsp_valid, 1);
    check("lat_rsp0_result", r0_if.rsp_result, 32'd12);
    check("lat_rsp0_tag", r0_if.rsp_tag, 3);
    check("lat_rsp0_illegal", r0_if.rsp_illegal, 0);
    step();
    check("lat_rsp0_drained", r0_if.rsp_valid, 0);

    // Contention: req0 was granted last, so req1 goes first, then alternate.
    drive0(1'b1, 7'h20, 3'b000, 32'd10, 32'd3, 4'd1);
    drive1(1'b1, 7'h20, 3'b101, 32'h8000_0000, 32'd4, 4'd2);
    for (int i = 0; i < 6; i++) begin
      #1;
      check("rr_req0_ready", r0_if.req_ready, (i % 2 == 1) ? 1 : 0);
      check("rr_req1_ready", r1_if.req_ready, (i % 2 == 0) ? 1 : 0);
      step();
      if (i % 2 == 1) begin
        check("rr_rsp0_valid", r0_if.rsp_valid, 1);
        check("rr_rsp0_result", r0_if.rsp_result, 32'd7);
        check("rr_rsp1_idle", r1_if.rsp_valid, 0);
      end else begin
        check("rr_rsp1_valid", r1_if.rsp_valid, 1);
        check("rr_rsp1_result", r1_if.rsp_result, 32'hF800_0000);
        check("rr_rsp1_tag", r1_if.rsp_tag, 2);
        check("rr_rsp0_idle", r0_if.rsp_valid, 0);
      end
    end
    drive0(1'b0, 7'h00, 3'b000, 32'd0, 32'd0, 4'd0);
    drive1(1'b0, 7'h00, 3'b000, 32'd0, 32'd0, 4'd0);
    step();

    // Backpressure on requester 1 while requester 0 keeps the ALU busy.
    r1_if.rsp_ready = 1'b0;
    drive1(1'b1, 7'h00, 3'b100, 32'hFF, 32'h0F, 4'd5);
    #1;
    check("bp_req1_first_grant", r1_if.req_ready, 1);
    step();
    check("bp_rsp1_result", r1_if.rsp_result, 32'hF0);
    drive1(1'b1, 7'h00, 3'b100, 32'h33, 32'h0F, 4'd6);
    for (int k = 0; k < 5; k++) begin
      drive0(1'b1, 7'h00, 3'b110, 32'h100, k, 4'd7);
      #1;
      check("bp_req1_ready", r1_if.req_ready, 0);
      check("bp_req0_ready", r0_if.req_ready, 1);
      step();
      check("bp_rsp1_valid", r1_if.rsp_valid, 1);
      check("bp_rsp1_hold", r1_if.rsp_result, 32'hF0);
      check("bp_rsp1_tag", r1_if.rsp_tag, 5);
      check("bp_rsp0_result", r0_if.rsp_result, 32'h100 | k);
    end
    drive0(1'b0, 7'h00, 3'b000, 32'd0, 32'd0, 4'd0);
    drive1(1'b0, 7'h00, 3'b000, 32'd0, 32'd0, 4'd0);
    r1_if.rsp_ready = 1'b1;
    step();
    check("bp_rsp1_drained", r1_if.rsp_valid, 0);

    // Drain and accept back to back: SLT then SLTU of -1 vs 1.
    drive0(1'b1, 7'h00, 3'b010, 32'hFFFF_FFFF, 32'd1, 4'd7);
    step();
    check("da_slt_valid", r0_if.rsp_valid, 1);
    check("da_slt_result", r0_if.rsp_result, 1);
    drive0(1'b1, 7'h00, 3'b011, 32'hFFFF_FFFF, 32'd1, 4'd8);
    step();
    check("da_sltu_valid", r0_if.rsp_valid, 1);
    check("da_sltu_result", r0_if.rsp_result, 0);
    check("da_sltu_tag", r0_if.rsp_tag, 8);
    drive0(1'b0, 7'h00, 3'b000, 32'd0, 32'd0, 4'd0);
    step();
    check("da_drained", r0_if.rsp_valid, 0);

    // Asynchronous reset mid-operation.
    r0_if.rsp_ready = 1'b0;
    drive0(1'b1, 7'h00, 3'b000, 32'd1, 32'd2, 4'd9);
    step();
    check("ar_rsp0_held", r0_if.rsp_valid, 1);
    drive0(1'b0, 7'h00, 3'b000, 32'd0, 32'd0, 4'd0);
    drive1(1'b1, 7'h00, 3'b000, 32'd4, 32'd4, 4'd10);
    #1;
    check("ar_req1_ready_pre", r1_if.req_ready, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_rsp0_cleared", r0_if.rsp_valid, 0);
    check("ar_req1_ready_rst", r1_if.req_ready, 0);
    drive1(1'b0, 7'h00, 3'b000, 32'd0, 32'd0, 4'd0);
    step();
    rst_n = 1'b1;
    step();
    check("ar_no_rsp0", r0_if.rsp_valid, 0);
    check("ar_no_rsp1", r1_if.rsp_valid, 0);
    r0_if.rsp_ready = 1'b1;
    drive0(1'b1, 7'h00, 3'b000, 32'd1, 32'd2, 4'd9);
    drive1(1'b1, 7'h00, 3'b000, 32'd4, 32'd4, 4'd10);
    #1;
    check("ar_req0_first", r0_if.req_ready, 1);
    check("ar_req1_waits", r1_if.req_ready, 0);
    step();
    check("ar_rsp0_result", r0_if.rsp_result, 3);
    #1;
    check("ar_req1_next", r1_if.req_ready, 1);
    step();
    check("ar_rsp1_result", r1_if.rsp_result, 8);
    drive0(1'b0, 7'h00, 3'b000, 32'd0, 32'd0, 4'd0);
    drive1(1'b0, 7'h00, 3'b000, 32'd0, 32'd0, 4'd0);
    step();

    // funct7=0100000 with funct3=001 is not a legal encoding.
    drive0(1'b1, 7'h20, 3'b001, 32'd5, 32'd5, 4'd11);
    step();
    check("il_tag", r0_if.rsp_tag, 11);
`ifdef ALU_ARB_ILLEGAL_CHK_EN
    check("il_flag", r0_if.rsp_illegal, 1);
    check("il_result", r0_if.rsp_result, 0);
`else
    check("il_flag", r0_if.rsp_illegal, 0);
`endif
    drive0(1'b1, 7'h20, 3'b000, 32'd9, 32'd4, 4'd12);
    step();
    check("il_legal_flag", r0_if.rsp_illegal, 0);
    check("il_legal_result", r0_if.rsp_result, 5);
    drive0(1'b0, 7'h00, 3'b000, 32'd0, 32'd0, 4'd0);
    step();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

`default_nettype wire
